// File: rtl/alu_md_unit_if.sv
// Execute-stage bus for alu_md_unit. The pipeline drives the operation
// request, and the unit returns its results and flags.
interface alu_md_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [4:0]       aluc;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] hi;
   logic             zero;
   logic             carry;
   logic             negative;
   logic             overflow;

   modport master (
      output start, aluc, a, b,
      input  busy, done, r, hi, zero, carry, negative, overflow
   );

   modport slave (
      input  start, aluc, a, b,
      output busy, done, r, hi, zero, carry, negative, overflow
   );
endinterface

// File: rtl/alu_md_unit.sv
// Registered ALU with an iterative multiply/divide unit. Codes 0-15 and
// 20-31 complete one edge after they are accepted. Codes 16-19 run a
// shift-add or restoring-divide loop for WIDTH cycles while busy is high.
module alu_md_unit #(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   alu_md_unit_if.slave bus
);
   localparam int SW = $clog2(WIDTH);
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] MD_RUN = 1'b1;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [0:0]       state;
   logic [SW-1:0]    cnt;
   logic             vld_p0;
   logic [4:0]       code_p0;
   logic [WIDTH-1:0] a_p0, b_p0;
   logic [WIDTH-1:0] acc_hi, acc_lo, mcand;
   logic [1:0]       md_op;
   logic             md_neg_q, md_neg_r, md_dz, md_ovf;

   logic             accept, is_md_in, sgn_in, md_last;
   logic [WIDTH:0]   sum, shifted;
   logic [WIDTH-1:0] diff, step_hi, step_lo, quo, rem;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] md_r, md_hi;
   logic             md_z, md_c, md_n, md_v;
   logic [SW-1:0]    sh;
   logic [WIDTH:0]   sum_s, shl;
   logic [WIDTH:0]   shr;
   logic [WIDTH-1:0] dif_s, sra;
   logic             lt_u, lt_s;
   logic [WIDTH-1:0] sc_r;
   logic             sc_z, sc_c, sc_n, sc_v;

   // Magnitude of a two's-complement operand when the operation is signed.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   assign is_md_in = (bus.aluc[4:2] == 3'b100);
   assign sgn_in   = bus.aluc[0];
   assign accept   = bus.start && (state == IDLE);
   assign md_last  = (state == MD_RUN) && (cnt == SW'(WIDTH - 1));
   assign bus.busy = (state == MD_RUN);

   // Control: the FSM, the iteration counter and the single-cycle valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= accept && !is_md_in;
         if (state == IDLE) begin
            if (accept && is_md_in) begin
               state <= MD_RUN;
               cnt   <= '0;
            end
         end else begin
            cnt <= cnt + SW'(1);
            if (md_last) state <= IDLE;
         end
      end
   end

   // Operand capture on accept, then one multiply/divide step per busy cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0     <= bus.a;
         b_p0     <= bus.b;
         code_p0  <= bus.aluc;
         md_op    <= bus.aluc[1:0];
         acc_hi   <= '0;
         acc_lo   <= mag(bus.a, sgn_in);
         mcand    <= mag(bus.b, sgn_in);
         md_neg_q <= sgn_in && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         md_neg_r <= sgn_in && bus.a[WIDTH-1];
         md_dz    <= (bus.b == '0);
         md_ovf   <= sgn_in && (bus.a == MIN_NEG) && (bus.b == '1);
      end else if (state == MD_RUN) begin
         acc_hi <= step_hi;
         acc_lo <= step_lo;
      end
   end

   // One iteration: restoring-divide bit or shift-add multiply bit.
   always_comb begin
      sum     = '0;
      shifted = '0;
      diff    = '0;
      step_hi = acc_hi;
      step_lo = acc_lo;
      if (md_op[1]) begin
         shifted = {acc_hi, acc_lo[WIDTH-1]};
         diff    = shifted[WIDTH-1:0] - mcand;
         if (shifted >= {1'b0, mcand}) begin
            step_hi = diff;
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = shifted[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
         step_hi = sum[WIDTH:1];
         step_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   // Sign restoration, special cases and flags for the final iteration.
   always_comb begin
      prod = {step_hi, step_lo};
      if (md_neg_q) prod = -prod;
      quo  = md_neg_q ? -step_lo : step_lo;
      rem  = md_neg_r ? -step_hi : step_hi;
      md_r = prod[WIDTH-1:0];
      md_hi = prod[2*WIDTH-1:WIDTH];
      md_c = 1'b0;
      md_n = 1'b0;
      md_v = 1'b0;
      case (md_op)
         2'b00: md_c = (md_hi != '0);
         2'b01: begin
            md_v = (md_hi != {WIDTH{md_r[WIDTH-1]}});
            md_n = md_hi[WIDTH-1];
         end
         default: begin
            if (md_dz) begin
               md_r  = '1;
               md_hi = a_p0;
               md_v  = 1'b1;
               md_c  = 1'b1;
            end else if (md_ovf) begin
               md_r  = MIN_NEG;
               md_hi = '0;
               md_v  = 1'b1;
            end else begin
               md_r  = quo;
               md_hi = rem;
            end
            md_n = md_op[0] && md_r[WIDTH-1];
         end
      endcase
      md_z = (md_r == '0) && (md_hi == '0);
   end

   // Single-cycle ALU operations evaluated on the captured operands.
   always_comb begin
      sh    = a_p0[SW-1:0];
      sum_s = {1'b0, a_p0} + {1'b0, b_p0};
      dif_s = a_p0 - b_p0;
      lt_u  = (a_p0 < b_p0);
      lt_s  = ($signed(a_p0) < $signed(b_p0));
      shl   = {1'b0, b_p0} << sh;
      shr   = {b_p0, 1'b0} >> sh;
      sra   = $unsigned($signed(b_p0) >>> sh);
      sc_r  = '0;
      sc_c  = 1'b0;
      sc_v  = 1'b0;
      case (code_p0)
         5'd0:  begin sc_r = sum_s[WIDTH-1:0]; sc_c = sum_s[WIDTH]; end
         5'd1:  begin sc_r = dif_s; sc_c = lt_u; end
         5'd2:  begin
            sc_r = sum_s[WIDTH-1:0];
            sc_v = (a_p0[WIDTH-1] == b_p0[WIDTH-1]) && (sc_r[WIDTH-1] != a_p0[WIDTH-1]);
         end
         5'd3:  begin
            sc_r = dif_s;
            sc_v = (a_p0[WIDTH-1] != b_p0[WIDTH-1]) && (sc_r[WIDTH-1] != a_p0[WIDTH-1]);
         end
         5'd4:  sc_r = a_p0 & b_p0;
         5'd5:  sc_r = a_p0 | b_p0;
         5'd6:  sc_r = a_p0 ^ b_p0;
         5'd7:  sc_r = ~(a_p0 | b_p0);
         5'd8, 5'd9: sc_r = {b_p0[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         5'd10: begin sc_r = {{(WIDTH-1){1'b0}}, lt_u}; sc_c = lt_u; end
         5'd11: sc_r = {{(WIDTH-1){1'b0}}, lt_s};
         5'd12: begin sc_r = sra; sc_c = shr[0]; end
         5'd13: begin sc_r = shr[WIDTH:1]; sc_c = shr[0]; end
         5'd14, 5'd15: begin sc_r = shl[WIDTH-1:0]; sc_c = shl[WIDTH]; end
         default: sc_r = '0;
      endcase
      sc_z = (sc_r == '0);
      sc_n = sc_r[WIDTH-1];
      if (code_p0 == 5'd10) begin
         sc_z = (a_p0 == b_p0);
      end else if (code_p0 == 5'd11) begin
         sc_z = (a_p0 == b_p0);
         sc_n = lt_s;
      end else if (code_p0 > 5'd15) begin
         sc_z = 1'b0;
         sc_n = 1'b0;
      end
   end

   // Result registers: updated only on completion and held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.done     <= 1'b0;
         bus.r        <= '0;
         bus.hi       <= '0;
         bus.zero     <= 1'b0;
         bus.carry    <= 1'b0;
         bus.negative <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (vld_p0) begin
            bus.done     <= 1'b1;
            bus.r        <= sc_r;
            bus.zero     <= sc_z;
            bus.carry    <= sc_c;
            bus.negative <= sc_n;
            bus.overflow <= sc_v;
         end else if (md_last) begin
            bus.done     <= 1'b1;
            bus.r        <= md_r;
            bus.hi       <= md_hi;
            bus.zero     <= md_z;
            bus.carry    <= md_c;
            bus.negative <= md_n;
            bus.overflow <= md_v;
         end
      end
   end
endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit: a vector table for the single-cycle
// codes, reference-model expectations for multiply/divide, and directed
// sequences for timing, ignored starts and reset during an operation.
module tb_alu_md_unit;
   localparam int W = 32;

   typedef struct {
      string        name;
      logic [W-1:0] r;
      logic [W-1:0] hi;
      logic [3:0]   f;   // {zero, carry, negative, overflow}
   } exp_t;

   typedef struct {
      logic [4:0]   code;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic [3:0]   f;
   } vec_t;

   logic clk;
   logic rst;
   alu_md_unit_if #(.WIDTH(W)) bus();

   alu_md_unit #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   exp_t         sb[$];
   vec_t         tv[28];
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] model_hi;
   int           busy_run;
   bit           last_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic exp_t md_model(input logic [4:0] code, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input string nm);
      exp_t        e;
      logic [63:0] up;
      longint      sp;
      int          sa, sb2;
      logic        z, c, n, v;
      sa = a;
      sb2 = b;
      c = 1'b0; n = 1'b0; v = 1'b0;
      e.name = nm;
      e.r = '0;
      e.hi = '0;
      case (code)
         5'd16: begin
            up = {32'b0, a} * {32'b0, b};
            e.r = up[31:0]; e.hi = up[63:32];
            c = (e.hi != 0);
         end
         5'd17: begin
            sp = longint'(sa) * longint'(sb2);
            up = sp;
            e.r = up[31:0]; e.hi = up[63:32];
            v = (e.hi != {32{e.r[31]}});
            n = e.hi[31];
         end
         5'd18: begin
            if (b == 0) begin
               e.r = 32'hFFFFFFFF; e.hi = a; v = 1'b1; c = 1'b1;
            end else begin
               e.r = a / b; e.hi = a % b;
            end
         end
         default: begin
            if (b == 0) begin
               e.r = 32'hFFFFFFFF; e.hi = a; v = 1'b1; c = 1'b1;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               e.r = 32'h80000000; e.hi = 0; v = 1'b1;
            end else begin
               e.r = sa / sb2; e.hi = sa % sb2;
            end
            n = e.r[31];
         end
      endcase
      z = (e.r == 0) && (e.hi == 0);
      e.f = {z, c, n, v};
      return e;
   endfunction

   // One clock: sample at the falling edge and score any completion.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      last_done = bus.done;
      if (bus.busy) busy_run++;
      if (bus.done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual r=%h required=no done", bus.r);
         end else begin
            e = sb.pop_front();
            chk({e.name, ".r"}, bus.r, e.r);
            chk({e.name, ".hi"}, bus.hi, e.hi);
            chk({e.name, ".flags"}, {28'b0, bus.zero, bus.carry, bus.negative, bus.overflow},
                {28'b0, e.f});
         end
      end
   endtask

   task automatic issue(input logic [4:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.aluc  = code;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start = 1'b0;
      bus.aluc  = 5'($urandom);
      bus.a     = $urandom;
      bus.b     = $urandom;
   endtask

   task automatic push_single(input string nm, input logic [W-1:0] r, input logic [3:0] f);
      exp_t e;
      e.name = nm; e.r = r; e.hi = model_hi; e.f = f;
      sb.push_back(e);
   endtask

   task automatic push_md(input string nm, input logic [4:0] code, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      exp_t e;
      e = md_model(code, a, b, nm);
      model_hi = e.hi;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (!last_done && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (!last_done) begin
         errors++;
         $display("FAIL %s.timeout actual=no done required=done within 100 cycles", nm);
      end
   endtask

   task automatic run_md(input string nm, input logic [4:0] code, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      push_md(nm, code, a, b);
      issue(code, a, b);
      wait_done(nm);
   endtask

   initial begin
      tv[0]  = '{5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100};
      tv[1]  = '{5'd1,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0110};
      tv[2]  = '{5'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011};
      tv[3]  = '{5'd3,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001};
      tv[4]  = '{5'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010};
      tv[5]  = '{5'd5,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000};
      tv[6]  = '{5'd6,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b1000};
      tv[7]  = '{5'd7,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0010};
      tv[8]  = '{5'd8,  32'hDEADBEEF, 32'h1234ABCD, 32'hABCD0000, 4'b0010};
      tv[9]  = '{5'd9,  32'h00000000, 32'hFFFF7FFF, 32'h7FFF0000, 4'b0000};
      tv[10] = '{5'd10, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0100};
      tv[11] = '{5'd10, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000};
      tv[12] = '{5'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0010};
      tv[13] = '{5'd11, 32'h00000003, 32'h00000003, 32'h00000000, 4'b1000};
      tv[14] = '{5'd11, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b0000};
      tv[15] = '{5'd12, 32'h00000024, 32'h80000018, 32'hF8000001, 4'b0110};
      tv[16] = '{5'd12, 32'h00000020, 32'h80000001, 32'h80000001, 4'b0010};
      tv[17] = '{5'd13, 32'hFFFFFFE4, 32'h80000018, 32'h08000001, 4'b0100};
      tv[18] = '{5'd13, 32'h0000001F, 32'h80000000, 32'h00000001, 4'b0000};
      tv[19] = '{5'd14, 32'h00000004, 32'h1000000F, 32'h000000F0, 4'b0100};
      tv[20] = '{5'd15, 32'h00000000, 32'h80000000, 32'h80000000, 4'b0010};
      tv[21] = '{5'd15, 32'h00000001, 32'h80000000, 32'h00000000, 4'b1100};
      tv[22] = '{5'd20, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0000};
      tv[23] = '{5'd31, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0000};
      tv[24] = '{5'd0,  32'h80000000, 32'h80000000, 32'h00000000, 4'b1100};
      tv[25] = '{5'd3,  32'h00000000, 32'h80000000, 32'h80000000, 4'b0011};
      tv[26] = '{5'd1,  32'h00000005, 32'h00000003, 32'h00000002, 4'b0000};
      tv[27] = '{5'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0010};

      rst = 1'b1;
      bus.start = 1'b0;
      bus.aluc = '0;
      bus.a = '0;
      bus.b = '0;
      model_hi = '0;
      busy_run = 0;
      last_done = 1'b0;

      #12;
      chk("reset.r", bus.r, 32'h0);
      chk("reset.hi", bus.hi, 32'h0);
      chk("reset.ctl", {26'b0, bus.busy, bus.done, bus.zero, bus.carry, bus.negative,
                        bus.overflow}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // ADDU latency: nothing one edge after accept, done on the next.
      busy_run = 0;
      push_single("addu_lat", 32'h0, 4'b1100);
      issue(5'd0, 32'hFFFFFFFF, 32'h1);
      chk("addu_lat.early", {30'b0, bus.busy, bus.done}, 32'h0);
      tick();
      chk("addu_lat.done", 32'(last_done), 32'h1);
      chk("addu_lat.busy_never", 32'(busy_run), 32'h0);

      // Back-to-back single-cycle table.
      for (int i = 0; i < 28; i++) begin
         push_single($sformatf("vec%0d_op%0d", i, tv[i].code), tv[i].r, tv[i].f);
         issue(tv[i].code, tv[i].a, tv[i].b);
      end
      tick();
      tick();

      // MULU of all ones: busy for exactly WIDTH cycles, done a single pulse.
      busy_run = 0;
      run_md("mulu_max", 5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("mulu_max.busy_cycles", 32'(busy_run), 32'd32);
      tick();
      chk("mulu_max.done_pulse", 32'(last_done), 32'h0);

      // Directed multiply/divide, each issued in the done cycle of the previous.
      run_md("div_m7_2", 5'd19, 32'hFFFFFFF9, 32'h2);
      run_md("div_min_m1", 5'd19, 32'h80000000, 32'hFFFFFFFF);
      run_md("mul_m3_5", 5'd17, 32'hFFFFFFFD, 32'h5);
      run_md("mul_ovf", 5'd17, 32'h00010000, 32'h00010000);
      run_md("mul_min_min", 5'd17, 32'h80000000, 32'h80000000);
      run_md("divu_100_7", 5'd18, 32'd100, 32'd7);
      run_md("div_7_m2", 5'd19, 32'd7, 32'hFFFFFFFE);
      run_md("div_m8_0", 5'd19, 32'hFFFFFFF8, 32'h0);
      run_md("mulu_zero", 5'd16, 32'h0, 32'd123);
      push_single("single_after_md", 32'h3, 4'b0000);
      issue(5'd5, 32'h1, 32'h2);
      tick();

      for (int i = 0; i < 6; i++) begin
         logic [4:0]   c;
         logic [W-1:0] x, y;
         c = 5'(16 + $urandom_range(0, 3));
         x = $urandom;
         y = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
         run_md($sformatf("rand%0d_op%0d", i, c), c, x, y);
      end

      // DIVU by zero with a start pulse in the middle that must be ignored.
      push_md("divu_dz", 5'd18, 32'd5, 32'h0);
      issue(5'd18, 32'd5, 32'h0);
      repeat (5) tick();
      bus.start = 1'b1;
      bus.aluc = 5'd0;
      bus.a = 32'h1;
      bus.b = 32'h2;
      tick();
      bus.start = 1'b0;
      wait_done("divu_dz");
      tick();

      // Reset during a MUL: everything clears at once, no done follows.
      issue(5'd17, 32'h00001234, 32'h00005678);
      repeat (9) tick();
      #2 rst = 1'b1;
      #1;
      chk("rst_mid.ctl", {26'b0, bus.busy, bus.done, bus.zero, bus.carry, bus.negative,
                          bus.overflow}, 32'h0);
      chk("rst_mid.r", bus.r, 32'h0);
      chk("rst_mid.hi", bus.hi, 32'h0);
      model_hi = '0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (40) tick();
      push_single("add_after_rst", 32'd5, 4'b0000);
      issue(5'd2, 32'd2, 32'd3);
      tick();
      chk("add_after_rst.done", 32'(last_done), 32'h1);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL pending_results actual=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_md_unit.md
Name: alu_md_unit

Overview:
Parametrised, registered successor to the CPU's combinational ALU. Executes the existing 16 ALU operations with one-cycle latency, and adds iterative multiply and divide (signed and unsigned) through a start/busy/done handshake. Sits in the execute stage. The datapath stalls on busy and latches r/hi on done.

Parameters:
WIDTH, 32, datapath width; must be even and a power of two, minimum 8; SW = log2(WIDTH) is derived internally.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  launch an operation; accepted only when idle
aluc  input  5  operation code, sampled with start
a  input  WIDTH  operand A; shift amount for shifts
b  input  WIDTH  operand B
busy  output  1  multi-cycle operation in progress
done  output  1  one-cycle pulse; results valid from this cycle
r  output  WIDTH  result; quotient for divide; low product for multiply
hi  output  WIDTH  high product or remainder; updated only by codes 16-19
zero  output  1  flag
carry  output  1  flag
negative  output  1  flag
overflow  output  1  flag

Behaviour:
- Reset: busy, done, r, hi and all flags = 0; FSM = IDLE; any in-flight operation is aborted with no done.
- FSM has 2 states: IDLE and MD_RUN.
- start is accepted in IDLE, including the cycle in which done pulses. start in MD_RUN is ignored; operands are not resampled.
- a, b and aluc are captured on the accepting edge. Later input changes do not affect the operation.
- Codes 0-15 are single-cycle: start accepted at edge N; r, flags and done=1 appear after edge N+1; busy stays 0.
- Code encoding and semantics:
  - 0 ADDU, 1 SUBU, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOR
  - 8, 9 LUI: r = b[WIDTH/2-1:0] followed by WIDTH/2 zeros
  - 10 SLTU, 11 SLT
  - 12 SRA, 13 SRL, 14 SLL, 15 SLL
  - Shift amount = a[SW-1:0]; upper bits of a are ignored.
- Flags for codes 0-15:
  - zero = (r==0), except SLT/SLTU where zero = (a==b).
  - carry: ADDU = carry-out; SUBU and SLTU = unsigned a<b; shifts = last bit shifted out, 0 when amount = 0; all others 0.
  - negative = r[MSB], except SLT where negative = signed a<b.
  - overflow: ADD/SUB signed overflow; 0 for all others.
- Codes 16 MULU, 17 MUL, 18 DIVU, 19 DIV:
  - On accept, enter MD_RUN; busy=1 for exactly WIDTH cycles.
  - On the next edge busy=0, done=1 and results are valid. Total latency is WIDTH+1 edges.
- Multiply: {hi,r} = full 2*WIDTH-bit product, shift-add one bit per cycle.
  - Signed multiply uses magnitudes, then negates the product if the operand signs differ.
  - MULU: carry = (hi!=0).
  - MUL: overflow = hi is not the sign extension of r.
- Divide: restoring, one quotient bit per cycle; r = quotient, hi = remainder.
  - Signed divide: quotient negative iff operand signs differ; remainder takes the sign of a (truncating division).
  - Divide by zero: r = all ones, hi = a, overflow=1, carry=1.
  - DIV of most-negative by -1: r = most-negative, hi=0, overflow=1.
- Mul/div flags: zero = (r==0 && hi==0); negative = hi[MSB] for MUL, r[MSB] for DIV, 0 for unsigned ops.
- Codes 20-31 are single-cycle: r=0, all flags 0, hi unchanged, done pulses.
- r, hi and the flags hold their values between completions. done is high for exactly one cycle per accepted start.

Test Plan:
- ADDU a=0xFFFFFFFF, b=1 -> one edge later: done=1, r=0, zero=1, carry=1, overflow=0, busy never 1.
- SRA a=0x24 (amount 4), b=0x80000018 -> r=0xF8000001, carry=1 (b[3]), negative=1.
- MULU a=b=0xFFFFFFFF -> busy high 32 cycles, done on edge 33, hi=0xFFFFFFFE, r=0x00000001, carry=1.
- DIV a=-7, b=2 -> r=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> r=0x80000000, hi=0, overflow=1.
- DIVU a=5, b=0 -> r=0xFFFFFFFF, hi=5, overflow=1. start pulsed mid-operation with other operands -> ignored, result unchanged.
- Reset asserted in cycle 10 of a MUL -> busy=0 and outputs 0 immediately, no done. New ADD start after reset release completes normally.
